// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the dcache port arbiter: bus data types, grant owner and
// the outstanding-response FIFO entry.
package dcache_port_arbiter_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  // TLB exception report returned by the mmu alongside dcache_data_ok.
  typedef struct packed {
    logic       valid;
    logic [4:0] exccode;
  } exception_t;

  typedef enum logic {
    OWN_LOAD  = 1'b0,
    OWN_STORE = 1'b1
  } grant_owner_e;

  // One accepted-but-unanswered DBus request.
  typedef struct packed {
    grant_owner_e owner;
    logic         cancel;
  } resp_entry_t;

  localparam int unsigned MAX_OUTSTANDING_DEF = 2;
  localparam int unsigned STARVE_LIMIT_DEF    = 4;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// DBus request/response bundle between the arbiter (master) and the
// dcache+mmu (slave).
interface dcache_port_arbiter_if;
  import dcache_port_arbiter_pkg::*;

  logic       dcache_req;
  logic       dcache_wr;
  logic [3:0] dcache_wstrb;
  logic [2:0] dcache_size;
  virt_t      dcache_addr;
  uint32_t    dcache_wdata;
  logic       dcache_addr_ok;
  logic       dcache_data_ok;
  uint32_t    dcache_rdata;
  exception_t data_tlb_ex;

  modport master (
    output dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr, dcache_wdata,
    input  dcache_addr_ok, dcache_data_ok, dcache_rdata, data_tlb_ex
  );

  modport slave (
    input  dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr, dcache_wdata,
    output dcache_addr_ok, dcache_data_ok, dcache_rdata, data_tlb_ex
  );
endinterface

// File: rtl/dcache_resp_fifo.sv
// Small in-order FIFO of outstanding DBus requests. cancel_loads_i marks every
// stored load entry as cancelled so its response is later dropped.
module dcache_resp_fifo
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  input  logic        cancel_loads_i,
  output resp_entry_t head_o,
  output logic        empty_o,
  output logic        full_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  // Occupancy flags and push/pop qualification (push into a full FIFO only with a pop).
  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == (AW+1)'(DEPTH));
    head_o  = mem_q[rd_ptr_q];
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
  end

  // Storage, pointers and count; the pushed entry already carries its own cancel bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (cancel_loads_i) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (mem_q[i].owner == OWN_LOAD) mem_q[i].cancel <= 1'b1;
      end
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single DBus port between the speculative load path and the
// store-buffer drain path, and routes in-order responses back to their owner.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       ld_req,
  input  logic [2:0] ld_size,
  input  virt_t      ld_addr,
  output logic       ld_addr_ok,
  output logic       ld_data_ok,
  output uint32_t    ld_rdata,
  output exception_t ld_ex,
  input  logic       st_req,
  input  logic       st_urgent,
  input  logic [3:0] st_wstrb,
  input  logic [2:0] st_size,
  input  virt_t      st_addr,
  input  uint32_t    st_wdata,
  output logic       st_addr_ok,
  output logic       st_data_ok,
  output exception_t st_ex,
  dcache_port_arbiter_if.master dbus
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic         lock_q;
  grant_owner_e lock_owner_q;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic         grant_vld, req_s, accept_s, is_st, resp_vld;
  grant_owner_e grant_owner;
  resp_entry_t  push_entry, head;
  logic         fifo_empty, fifo_full;

  // Grant selection; a locked owner keeps the port until the DBus accepts it.
  always_comb begin
    grant_vld   = 1'b0;
    grant_owner = OWN_LOAD;
    if (lock_q) begin
      grant_vld   = 1'b1;
      grant_owner = lock_owner_q;
    end else if (st_req && (st_urgent || starve_cnt_q == SW'(STARVE_LIMIT))) begin
      grant_vld   = 1'b1;
      grant_owner = OWN_STORE;
    end else if (ld_req && !flush) begin
      grant_vld   = 1'b1;
      grant_owner = OWN_LOAD;
    end else if (st_req) begin
      grant_vld   = 1'b1;
      grant_owner = OWN_STORE;
    end
  end

  // Combinational request path and addr_ok return to the granted requester.
  always_comb begin
    is_st     = (grant_owner == OWN_STORE);
    req_s     = grant_vld & ~fifo_full & ~reset;
    accept_s  = req_s & dbus.dcache_addr_ok;
    dbus.dcache_req   = req_s;
    dbus.dcache_wr    = 1'b0;
    dbus.dcache_wstrb = '0;
    dbus.dcache_size  = '0;
    dbus.dcache_addr  = '0;
    dbus.dcache_wdata = '0;
    if (req_s) begin
      if (is_st) begin
        dbus.dcache_wr    = 1'b1;
        dbus.dcache_wstrb = st_wstrb;
        dbus.dcache_size  = st_size;
        dbus.dcache_addr  = st_addr;
        dbus.dcache_wdata = st_wdata;
      end else begin
        dbus.dcache_size  = ld_size;
        dbus.dcache_addr  = ld_addr;
      end
    end
    ld_addr_ok        = accept_s & ~is_st & ~flush;
    st_addr_ok        = accept_s & is_st;
    push_entry.owner  = grant_owner;
    push_entry.cancel = ~is_st & flush;
  end

  // Response routing from the FIFO head; a load returning in a flush cycle is dropped too.
  always_comb begin
    resp_vld   = dbus.dcache_data_ok & ~fifo_empty & ~reset;
    st_data_ok = resp_vld & (head.owner == OWN_STORE);
    ld_data_ok = resp_vld & (head.owner == OWN_LOAD) & ~head.cancel & ~flush;
    st_ex      = st_data_ok ? dbus.data_tlb_ex : '0;
    ld_ex      = ld_data_ok ? dbus.data_tlb_ex : '0;
    ld_rdata   = ld_data_ok ? dbus.dcache_rdata : '0;
  end

  // Starvation counter: consecutive load accepts while a store waits, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!st_req || st_addr_ok)
      starve_cnt_d = '0;
    else if (accept_s && !is_st && starve_cnt_q != SW'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Lock owner and starvation state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_LOAD;
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (req_s) begin
        lock_q       <= ~dbus.dcache_addr_ok;
        lock_owner_q <= grant_owner;
      end
    end
  end

  dcache_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (accept_s),
    .push_entry_i   (push_entry),
    .pop_i          (dbus.dcache_data_ok),
    .cancel_loads_i (flush),
    .head_o         (head),
    .empty_o        (fifo_empty),
    .full_o         (fifo_full)
  );
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a request tracker predicts grants
// and pushes expected responses; a response monitor pops and compares.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int unsigned MAXO   = 2;
  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic reset, flush;
  logic ld_req; logic [2:0] ld_size; virt_t ld_addr;
  logic ld_addr_ok, ld_data_ok; uint32_t ld_rdata; exception_t ld_ex;
  logic st_req, st_urgent; logic [3:0] st_wstrb; logic [2:0] st_size;
  virt_t st_addr; uint32_t st_wdata;
  logic st_addr_ok, st_data_ok; exception_t st_ex;

  dcache_port_arbiter_if dbus ();

  dcache_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ld_req(ld_req), .ld_size(ld_size), .ld_addr(ld_addr),
    .ld_addr_ok(ld_addr_ok), .ld_data_ok(ld_data_ok), .ld_rdata(ld_rdata), .ld_ex(ld_ex),
    .st_req(st_req), .st_urgent(st_urgent), .st_wstrb(st_wstrb), .st_size(st_size),
    .st_addr(st_addr), .st_wdata(st_wdata),
    .st_addr_ok(st_addr_ok), .st_data_ok(st_data_ok), .st_ex(st_ex),
    .dbus(dbus.master)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_store; bit killed; } exp_t;
  exp_t exp_q[$];

  int  total = 0, bad = 0;
  bit  running = 0;
  bit  popped_now = 0;
  bit  m_lock = 0, m_lock_store = 0;
  int  m_starve = 0;
  bit  ld_hold = 0, st_hold = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Response monitor: pops the oldest outstanding expectation on each data_ok.
  always @(negedge clk) begin
    popped_now = 0;
    if (running && !reset) begin
      bit e_ld, e_st;
      exp_t e;
      e_ld = 0; e_st = 0;
      if (dbus.dcache_data_ok && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped_now = 1;
        e_st = e.is_store;
        e_ld = !e.is_store && !e.killed && !flush;
      end
      chk("st_data_ok", 32'(st_data_ok), 32'(e_st));
      chk("ld_data_ok", 32'(ld_data_ok), 32'(e_ld));
      if (e_ld) begin
        chk("ld_rdata", ld_rdata, dbus.dcache_rdata);
        chk("ld_ex", 32'(ld_ex), 32'(dbus.data_tlb_ex));
      end
      if (e_st) chk("st_ex", 32'(st_ex), 32'(dbus.data_tlb_ex));
    end
  end

  // Request tracker: predicts the grant from the arbitration rules and records accepts.
  always @(negedge clk) begin
    #1;
    if (running && !reset) begin
      bit exp_req, exp_store, aok;
      exp_req = 0; exp_store = 0;
      aok = dbus.dcache_addr_ok;
      if (m_lock) begin exp_req = 1; exp_store = m_lock_store; end
      else if (st_req && (st_urgent || m_starve >= STARVE)) begin exp_req = 1; exp_store = 1; end
      else if (ld_req && !flush) begin exp_req = 1; exp_store = 0; end
      else if (st_req) begin exp_req = 1; exp_store = 1; end
      if (exp_q.size() + int'(popped_now) >= MAXO) exp_req = 0;

      chk("dcache_req", 32'(dbus.dcache_req), 32'(exp_req));
      if (exp_req) begin
        chk("dcache_wr", 32'(dbus.dcache_wr), 32'(exp_store));
        if (exp_store) begin
          chk("st_addr", dbus.dcache_addr, st_addr);
          chk("st_wdata", dbus.dcache_wdata, st_wdata);
          chk("st_wstrb", 32'(dbus.dcache_wstrb), 32'(st_wstrb));
          chk("st_size", 32'(dbus.dcache_size), 32'(st_size));
        end else begin
          chk("ld_addr", dbus.dcache_addr, ld_addr);
          chk("ld_size", 32'(dbus.dcache_size), 32'(ld_size));
        end
      end
      chk("ld_addr_ok", 32'(ld_addr_ok), 32'(exp_req && !exp_store && aok && !flush));
      chk("st_addr_ok", 32'(st_addr_ok), 32'(exp_req && exp_store && aok));

      if (flush) foreach (exp_q[i]) if (!exp_q[i].is_store) exp_q[i].killed = 1;
      if (exp_req && aok) exp_q.push_back('{is_store: exp_store, killed: !exp_store && flush});
      if (exp_req) begin m_lock = !aok; m_lock_store = exp_store; end
      if (!st_req || (exp_req && exp_store && aok)) m_starve = 0;
      else if (exp_req && !exp_store && aok && m_starve < STARVE) m_starve++;

      ld_hold = ld_req && !(exp_req && !exp_store && aok) && !(flush && !(exp_req && !exp_store));
      st_hold = st_req && !(exp_req && exp_store && aok);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit lr, input virt_t la, input bit sr, input bit urg,
                       input bit aok, input bit dok, input uint32_t rd, input bit fl);
    ld_req = lr; ld_addr = la; ld_size = 3'd2;
    st_req = sr; st_urgent = urg; st_addr = 32'h0000_1000; st_wdata = 32'h1234_5678;
    st_wstrb = 4'hF; st_size = 3'd2;
    dbus.dcache_addr_ok = aok; dbus.dcache_data_ok = dok; dbus.dcache_rdata = rd;
    dbus.data_tlb_ex = '{valid: 1'b1, exccode: 5'd7};
    flush = fl;
  endtask

  task automatic rand_cycle(input bit allow_new);
    logic [5:0] ex6;
    if (!ld_hold) begin
      ld_req = allow_new && ($urandom % 3 != 0);
      ld_addr = $urandom; ld_size = 3'($urandom % 3);
    end
    if (!st_hold) begin
      st_req = allow_new && ($urandom % 2 == 0);
      st_addr = $urandom; st_wdata = $urandom; st_wstrb = 4'($urandom); st_size = 3'($urandom % 3);
    end
    st_urgent = ($urandom % 5 == 0);
    flush = allow_new && ($urandom % 12 == 0);
    dbus.dcache_addr_ok = allow_new ? ($urandom % 3 != 0) : 1'b1;
    if (exp_q.size() > 0) dbus.dcache_data_ok = allow_new ? 1'($urandom % 2) : 1'b1;
    else dbus.dcache_data_ok = ($urandom % 16 == 0);
    dbus.dcache_rdata = $urandom;
    ex6 = 6'($urandom);
    dbus.data_tlb_ex = ex6;
  endtask

  initial begin
    reset = 1;
    drive(1, 32'h8000_1004, 1, 1, 1, 1, 32'hFFFF_FFFF, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_dcache_req", 32'(dbus.dcache_req), 0);
      chk("rst_ld_addr_ok", 32'(ld_addr_ok), 0);
      chk("rst_st_addr_ok", 32'(st_addr_ok), 0);
      chk("rst_ld_data_ok", 32'(ld_data_ok), 0);
      chk("rst_st_data_ok", 32'(st_data_ok), 0);
    end
    @(posedge clk); #1;
    reset = 0; running = 1;

    // Single load, response two cycles later.
    drive(1, 32'h8000_1004, 0, 0, 1, 0, 0, 0);           step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);           step();
    // Load and store together: load first, then store.
    drive(1, 32'h8000_2000, 1, 0, 1, 0, 0, 0);           step();
    drive(0, 0, 1, 0, 1, 0, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h1111_2222, 0);           step();
    drive(0, 0, 0, 0, 0, 1, 32'h3333_4444, 0);           step();
    // Load accepted, flushed while in flight, then a stray data_ok.
    drive(1, 32'h8000_3000, 0, 0, 1, 0, 0, 0);           step();
    drive(0, 0, 0, 0, 0, 0, 0, 1);                       step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h5555_6666, 0);           step();
    drive(0, 0, 0, 0, 0, 1, 32'h7777_8888, 0);           step();
    // Store accepted then flush: response still delivered.
    drive(0, 0, 1, 0, 1, 0, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 0, 0, 1);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h9999_AAAA, 0);           step();
    // Locked load while store turns urgent; then fill the FIFO.
    drive(1, 32'h8000_4000, 1, 0, 0, 0, 0, 0);           step();
    drive(1, 32'h8000_4000, 1, 1, 0, 0, 0, 0);           step();
    drive(1, 32'h8000_4000, 1, 1, 0, 0, 0, 0);           step();
    drive(1, 32'h8000_4000, 1, 1, 1, 0, 0, 0);           step();
    drive(0, 0, 1, 1, 1, 0, 0, 0);                       step();
    drive(1, 32'h8000_5000, 0, 0, 1, 0, 0, 0);           step();
    drive(1, 32'h8000_5000, 0, 0, 1, 1, 32'hABCD_0001, 0); step();
    drive(1, 32'h8000_5000, 0, 0, 1, 1, 32'hABCD_0002, 0); step();
    drive(0, 0, 0, 0, 0, 1, 32'hABCD_0003, 0);           step();
    // Continuous loads with a pending store: store forced after the starvation limit.
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h8000_6000 + 32'(i), 1, 0, 1, (exp_q.size() > 0), 32'(i), 0);
      step();
    end

    for (int i = 0; i < 3000; i++) begin
      rand_cycle(1);
      step();
    end
    begin
      int n;
      n = 0;
      while ((ld_hold || st_hold || exp_q.size() > 0) && n < 60) begin
        rand_cycle(0);
        step();
        n++;
      end
      chk("drain_timeout", 32'(n < 60), 1);
    end
    running = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
